sdram_frame_arbiter: RTL and testbench

Shares the single SDRAM port between two requesters. The video line fetcher reads the front frame buffer; the draw engine reads and writes the back frame buffer. The block also owns the double-buffer flip: it swaps the front and back buffers at `new_frame` only once the draw engine has reported its frame complete. It sits between the line-buffer fetcher/draw engine and the SDRAM controller.

---
 rtl/sdram_frame_arbiter_if.sv | 42 ++++
 rtl/sdram_frame_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_frame_arbiter_if.sv
// rtl/sdram_frame_arbiter_if.sv - requester, controller and frame-sync signals around the SDRAM frame arbiter
interface sdram_frame_arbiter_if;
  logic         vid_req;
  logic [19:0]  vid_offset;
  logic         vid_ack;
  logic [127:0] vid_rdata;

  logic         drw_req;
  logic         drw_we;
  logic [19:0]  drw_offset;
  logic [127:0] drw_wdata;
  logic         drw_ack;
  logic [127:0] drw_rdata;
  logic         drw_frame_done;
  logic         drw_frame_start;

  logic         new_frame;
  logic         frame_flip;
  logic [7:0]   dropped_frames;

  logic [21:0]  sdram_addr;
  logic         sdram_rd;
  logic         sdram_wr;
  logic [127:0] sdram_wdata;
  logic [127:0] sdram_rdata;
  logic         sdram_ac;
  logic         sdram_wait;

  modport master (
    output vid_req, vid_offset, drw_req, drw_we, drw_offset, drw_wdata,
           drw_frame_done, new_frame, sdram_rdata, sdram_ac, sdram_wait,
    input  vid_ack, vid_rdata, drw_ack, drw_rdata, drw_frame_start,
           frame_flip, dropped_frames, sdram_addr, sdram_rd, sdram_wr, sdram_wdata
  );

  modport slave (
    input  vid_req, vid_offset, drw_req, drw_we, drw_offset, drw_wdata,
           drw_frame_done, new_frame, sdram_rdata, sdram_ac, sdram_wait,
    output vid_ack, vid_rdata, drw_ack, drw_rdata, drw_frame_start,
           frame_flip, dropped_frames, sdram_addr, sdram_rd, sdram_wr, sdram_wdata
  );
endinterface

// File: rtl/sdram_frame_arbiter.sv
// rtl/sdram_frame_arbiter.sv - shares one SDRAM port between video fetch and draw engine, owns the buffer flip
module sdram_frame_arbiter #(
  parameter logic [21:0] ADDR1       = 22'h100000,
  parameter logic [21:0] ADDR2       = 22'h200000,
  parameter int unsigned VID_MAX_RUN = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sdram_frame_arbiter_if.slave io_bus
);
  localparam int RUN_W = $clog2(VID_MAX_RUN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_VID, ST_DRW} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic         r_frame_flip;
  logic         r_back_ready;
  logic         r_frame_start;
  logic         r_we;
  logic [RUN_W-1:0] r_run_cnt;
  logic [7:0]   r_dropped;
  logic [21:0]  r_addr;
  logic [127:0] r_wdata;

  logic         w_drw_elig;
  logic         w_run_limit;
  logic         w_grant_vid;
  logic         w_grant_drw;
  logic         w_flip;
  logic [21:0]  w_front_base;
  logic [21:0]  w_back_base;
  logic         w_sdram_rd;
  logic         w_sdram_wr;
  logic         w_vid_ack;
  logic         w_drw_ack;

  // A finished back buffer blocks drawing until the flip hands a fresh one over.
  assign w_drw_elig   = io_bus.drw_req & ~r_back_ready;
  assign w_run_limit  = (r_run_cnt == RUN_W'(VID_MAX_RUN));
  assign w_front_base = r_frame_flip ? ADDR1 : ADDR2;
  assign w_back_base  = r_frame_flip ? ADDR2 : ADDR1;
  assign w_grant_vid  = (r_state == ST_IDLE) && (w_next_state == ST_VID);
  assign w_grant_drw  = (r_state == ST_IDLE) && (w_next_state == ST_DRW);
  assign w_flip       = io_bus.new_frame & (r_back_ready | io_bus.drw_frame_done);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!io_bus.sdram_wait) begin
          if (io_bus.vid_req && !(w_run_limit && w_drw_elig)) begin
            w_next_state = ST_VID;
          end else if (w_drw_elig) begin
            w_next_state = ST_DRW;
          end
        end
      end
      ST_VID:  if (io_bus.sdram_ac) w_next_state = ST_IDLE;
      ST_DRW:  if (io_bus.sdram_ac) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them without a clock.
  always_comb begin
    w_sdram_rd = 1'b0;
    w_sdram_wr = 1'b0;
    w_vid_ack  = 1'b0;
    w_drw_ack  = 1'b0;
    case (r_state)
      ST_VID: begin
        w_sdram_rd = 1'b1;
        w_vid_ack  = io_bus.sdram_ac;
      end
      ST_DRW: begin
        w_sdram_rd = ~r_we;
        w_sdram_wr = r_we;
        w_drw_ack  = io_bus.sdram_ac;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_grant_vid) begin
      r_addr <= w_front_base + {2'b00, io_bus.vid_offset};
      r_we   <= 1'b0;
    end else if (w_grant_drw) begin
      r_addr  <= w_back_base + {2'b00, io_bus.drw_offset};
      r_wdata <= io_bus.drw_wdata;
      r_we    <= io_bus.drw_we;
    end
  end

  // Counts video grants that jumped ahead of a waiting draw request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run_cnt <= '0;
    end else if (!io_bus.drw_req || w_grant_drw) begin
      r_run_cnt <= '0;
    end else if (w_grant_vid && w_drw_elig) begin
      r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_flip  <= 1'b0;
      r_back_ready  <= 1'b0;
      r_frame_start <= 1'b0;
      r_dropped     <= 8'd0;
    end else begin
      r_frame_start <= w_flip;
      if (w_flip) begin
        r_frame_flip <= ~r_frame_flip;
        r_back_ready <= 1'b0;
      end else if (io_bus.drw_frame_done) begin
        r_back_ready <= 1'b1;
      end
      if (io_bus.new_frame && !w_flip && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end
    end
  end

  assign io_bus.sdram_rd        = w_sdram_rd;
  assign io_bus.sdram_wr        = w_sdram_wr;
  assign io_bus.sdram_addr      = r_addr;
  assign io_bus.sdram_wdata     = r_wdata;
  assign io_bus.vid_ack         = w_vid_ack;
  assign io_bus.drw_ack         = w_drw_ack;
  assign io_bus.vid_rdata       = io_bus.sdram_rdata;
  assign io_bus.drw_rdata       = io_bus.sdram_rdata;
  assign io_bus.frame_flip      = r_frame_flip;
  assign io_bus.drw_frame_start = r_frame_start;
  assign io_bus.dropped_frames  = r_dropped;
endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb/tb_sdram_frame_arbiter.sv - directed scoreboard bench for the SDRAM frame arbiter
module tb_sdram_frame_arbiter;
  localparam logic [21:0] ADDR1 = 22'h100000;
  localparam logic [21:0] ADDR2 = 22'h200000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_frame_arbiter_if bus();

  sdram_frame_arbiter #(.ADDR1(ADDR1), .ADDR2(ADDR2), .VID_MAX_RUN(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  typedef struct packed {
    logic         is_vid;
    logic         we;
    logic [21:0]  addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_flip = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, want);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_vid(input logic [19:0] off);
    exp_t e;
    e.is_vid = 1'b1;
    e.we     = 1'b0;
    e.addr   = (exp_flip ? ADDR1 : ADDR2) + {2'b00, off};
    e.wdata  = '0;
    sb.push_back(e);
  endtask

  task automatic push_drw(input logic [19:0] off, input logic we, input logic [127:0] wd);
    exp_t e;
    e.is_vid = 1'b0;
    e.we     = we;
    e.addr   = (exp_flip ? ADDR2 : ADDR1) + {2'b00, off};
    e.wdata  = wd;
    sb.push_back(e);
  endtask

  task automatic grab();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.sdram_rd || bus.sdram_wr) found = 1'b1;
    end
    chk1("grant_seen", found, 1'b1);
    chk1("sb_nonempty", sb.size() != 0, 1'b1);
    if (found && sb.size() != 0) begin
      cur = sb.pop_front();
      chkw("sdram_addr", 128'(bus.sdram_addr), 128'(cur.addr));
      chk1("sdram_rd", bus.sdram_rd, ~cur.we);
      chk1("sdram_wr", bus.sdram_wr, cur.we);
      if (cur.we) chkw("sdram_wdata", bus.sdram_wdata, cur.wdata);
      chk1("no_early_ack", bus.vid_ack | bus.drw_ack, 1'b0);
    end
  endtask

  task automatic finish_txn(input int delay, input bit release_req);
    logic [127:0] rd;
    repeat (delay - 1) @(negedge clk);
    rd = {$urandom, $urandom, $urandom, $urandom};
    bus.sdram_rdata = rd;
    bus.sdram_ac    = 1'b1;
    #1;
    chk1("vid_ack", bus.vid_ack, cur.is_vid);
    chk1("drw_ack", bus.drw_ack, ~cur.is_vid);
    chkw(cur.is_vid ? "vid_rdata" : "drw_rdata", cur.is_vid ? bus.vid_rdata : bus.drw_rdata, rd);
    @(negedge clk);
    bus.sdram_ac = 1'b0;
    if (release_req) begin
      bus.vid_req = 1'b0;
      bus.drw_req = 1'b0;
    end
    #1;
    chk1("idle_after_ack", bus.sdram_rd | bus.sdram_wr, 1'b0);
    chk1("ack_low_in_idle", bus.vid_ack | bus.drw_ack, 1'b0);
  endtask

  task automatic pulse_nf();
    @(negedge clk);
    bus.new_frame = 1'b1;
    @(negedge clk);
    bus.new_frame = 1'b0;
  endtask

  initial begin
    logic [127:0] wd;
    bus.vid_req = 0; bus.vid_offset = '0; bus.drw_req = 0; bus.drw_we = 0;
    bus.drw_offset = '0; bus.drw_wdata = '0; bus.drw_frame_done = 0;
    bus.new_frame = 0; bus.sdram_rdata = '0; bus.sdram_ac = 0; bus.sdram_wait = 0;

    // reset state
    @(negedge clk);
    chk1("rst_rd", bus.sdram_rd, 1'b0);
    chk1("rst_wr", bus.sdram_wr, 1'b0);
    chk1("rst_acks", bus.vid_ack | bus.drw_ack, 1'b0);
    chk1("rst_start", bus.drw_frame_start, 1'b0);
    chk1("rst_flip", bus.frame_flip, 1'b0);
    chkw("rst_dropped", 128'(bus.dropped_frames), 128'd0);
    chkw("rst_addr", 128'(bus.sdram_addr), 128'd0);
    chkw("rst_wdata", bus.sdram_wdata, 128'd0);

    // priority: both requesters held; eight video grants then the guard forces draw
    bus.vid_req = 1; bus.vid_offset = 20'h00040;
    bus.drw_req = 1; bus.drw_we = 1; bus.drw_offset = 20'h00100;
    wd = {4{32'hA5A5_0001}};
    bus.drw_wdata = wd;
    rst = 0;
    for (int i = 0; i < 8; i++) push_vid(20'h00040);
    push_drw(20'h00100, 1'b1, wd);
    for (int i = 0; i < 9; i++) begin
      grab();
      finish_txn(2, i == 8);
    end
    chkw("prio_dropped", 128'(bus.dropped_frames), 128'd0);

    // addressing
    bus.vid_offset = 20'h00028; bus.vid_req = 1;
    push_vid(20'h00028);
    grab();
    finish_txn(1, 1);
    wd = {4{32'h1234_5678}};
    bus.drw_offset = '0; bus.drw_we = 1; bus.drw_wdata = wd; bus.drw_req = 1;
    push_drw(20'h0, 1'b1, wd);
    grab();
    finish_txn(3, 1);

    // drop without a finished frame
    for (int i = 0; i < 3; i++) pulse_nf();
    chk1("drop_flip", bus.frame_flip, 1'b0);
    chkw("drop_count3", 128'(bus.dropped_frames), 128'd3);

    // flip, with a draw read held across it
    @(negedge clk);
    bus.drw_frame_done = 1;
    @(negedge clk);
    bus.drw_frame_done = 0;
    bus.drw_req = 1; bus.drw_we = 0; bus.drw_offset = 20'h0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk1("held_draw", bus.sdram_rd | bus.sdram_wr, 1'b0);
      chk1("no_start_yet", bus.drw_frame_start, 1'b0);
    end
    bus.new_frame = 1;
    #1 chk1("flip_before_edge", bus.frame_flip, 1'b0);
    @(negedge clk);
    bus.new_frame = 0;
    exp_flip = 1'b1;
    chk1("flip_after_edge", bus.frame_flip, 1'b1);
    chk1("start_pulse", bus.drw_frame_start, 1'b1);
    chk1("no_grant_flip_cycle", bus.sdram_rd | bus.sdram_wr, 1'b0);
    push_drw(20'h0, 1'b0, '0);
    @(negedge clk);
    chk1("start_one_cycle", bus.drw_frame_start, 1'b0);
    grab();
    finish_txn(2, 1);
    chkw("flip_dropped", 128'(bus.dropped_frames), 128'd3);

    // saturation
    for (int i = 0; i < 300; i++) pulse_nf();
    chkw("drop_sat", 128'(bus.dropped_frames), 128'd255);
    chk1("sat_flip", bus.frame_flip, 1'b1);

    // wait holds off the grant; wait during a grant is ignored
    bus.sdram_wait = 1; bus.vid_offset = 20'h00123; bus.vid_req = 1;
    push_vid(20'h00123);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("wait_no_rd", bus.sdram_rd, 1'b0);
    end
    bus.sdram_wait = 0;
    @(negedge clk);
    chk1("rd_after_wait", bus.sdram_rd, 1'b1);
    grab();
    bus.sdram_wait = 1;
    finish_txn(2, 1);
    bus.sdram_wait = 0;

    // asynchronous reset mid draw write
    wd = {4{32'hDEAD_BEEF}};
    bus.drw_offset = 20'h00055; bus.drw_we = 1; bus.drw_wdata = wd; bus.drw_req = 1;
    push_drw(20'h00055, 1'b1, wd);
    grab();
    #2 rst = 1;
    #1;
    chk1("arst_wr", bus.sdram_wr, 1'b0);
    chk1("arst_flip", bus.frame_flip, 1'b0);
    chkw("arst_dropped", 128'(bus.dropped_frames), 128'd0);
    chkw("arst_addr", 128'(bus.sdram_addr), 128'd0);
    exp_flip = 1'b0;
    @(negedge clk);
    rst = 0;
    push_drw(20'h00055, 1'b1, wd);
    grab();
    finish_txn(2, 1);
    chk1("post_rst_start", bus.drw_frame_start, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
